mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1, sets how many cycles ram_enable is held high per access (legal values 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch-port request; held high until if_ack.
REQ-005 if_addr  input  32  fetch byte address; always a word read.
REQ-006 if_ack  output  1  one-cycle pulse; fetch access complete.
REQ-007 if_rdata  output  32  fetched word; valid from the if_ack cycle until the next fetch grant.
REQ-008 dm_req  input  1  data-port request; held high until dm_ack.
REQ-009 dm_rw  input  1  0 = read, 1 = write.
REQ-010 dm_size  input  2  00 = byte, 01 = half-word, 10 = word, 11 = illegal.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  write data, right-justified.
REQ-013 dm_ack  output  1  one-cycle pulse; data access complete.
REQ-014 dm_err  output  1  valid with dm_ack; 1 = access rejected.
REQ-015 dm_rdata  output  32  read data; valid from the dm_ack cycle until the next data grant.
REQ-016 ram_enable, ram_rw (1), ram_addr (32), ram_din (32), ram_size (2)  outputs  drive the shared byte-addressed RAM port.
REQ-017 ram_dout  input  32  RAM read data.

Function
REQ-018 The FSM SHALL use the states IDLE, SETUP, STROBE and DONE.
REQ-019 IDLE: a pending request SHALL latch the winner's address, size, rw and wdata into the ram_* registers and go to SETUP; with no request it SHALL stay in IDLE.
REQ-020 SETUP: ram_enable SHALL be 0 for exactly one cycle (address/data setup), then the FSM goes to STROBE.
REQ-021 STROBE: ram_enable SHALL be 1 for exactly ACCESS_CYCLES cycles, counted by a 4-bit counter, then the FSM goes to DONE.
REQ-022 DONE: ram_enable SHALL be 0; ram_dout is captured into the winner's rdata on reads; the winner's ack pulses for one cycle; the next state is IDLE.
REQ-023 Latency: a request seen in IDLE in cycle N SHALL produce its ack in cycle N+2+ACCESS_CYCLES.
REQ-024 Fetch grants SHALL drive ram_rw=0 and ram_size=10.
REQ-025 ram_addr, ram_size, ram_rw and ram_din SHALL stay constant from SETUP through DONE.
REQ-026 Fixed priority: on simultaneous requests, the data port SHALL win.
REQ-027 Misaligned access (size 01 with addr[0]=1, or size 10 with addr[1:0]!=00) or dm_size=11 SHALL skip SETUP/STROBE, go directly to DONE, and pulse dm_ack with dm_err=1; no RAM strobe occurs, no memory is modified, and dm_rdata is unchanged.
REQ-028 A fetch address with if_addr[1:0]!=00 SHALL be forced to word alignment, i.e. bits [1:0] cleared.
REQ-029 A request dropped before its ack SHALL still complete its access and pulse its ack.
REQ-030 Only one ack SHALL be high in any cycle, and ack SHALL never assert outside DONE.
REQ-031 After DONE, the FSM SHALL pass through IDLE for at least one cycle before the next SETUP.

Reset
REQ-032 While reset is high: state = IDLE; ram_enable, ram_rw, if_ack, dm_ack and dm_err = 0; ram_addr, ram_din, if_rdata and dm_rdata = 0; ram_size = 10; strobe counter = 0.
REQ-033 Reset during SETUP, STROBE or DONE SHALL abort the access: ram_enable drops at that edge and no ack is issued for the aborted request.

Configuration
REQ-034 Macro MEM_ARB_RR_EN: when defined, simultaneous requests SHALL be granted round-robin using a 1-bit last-granted pointer (reset value = fetch, so the data port wins first); when undefined, the fixed priority of REQ-026 applies and no pointer exists.

Verification
REQ-035 Data word read, addr 8, ACCESS_CYCLES=1 -> ram_enable high exactly 1 cycle, dm_ack at N+3, dm_rdata = RAM word at 8, dm_err=0.
REQ-036 Byte write 0xB5 to addr 0, then half-word write 0xFFD3 to addr 2 -> ram_size 00 then 01; a following word read of addr 0 returns bytes 0xB5 at addr 0 and 0xFFD3 at addr 2..3, in the RAM's byte order.
REQ-037 Half-word read at addr 3 -> dm_ack with dm_err=1 at N+1, ram_enable never high, dm_rdata unchanged.
REQ-038 if_req and dm_req both high for 4 grants -> fixed priority: all 4 grants go to the data port; with MEM_ARB_RR_EN: grant order dm, if, dm, if.
REQ-039 reset asserted in the first STROBE cycle with ACCESS_CYCLES=3 -> ram_enable 0 at the next edge, no ack, all outputs at REQ-032 values, and a new request afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and data requesters; ack comes 2+ACCESS_CYCLES cycles after grant (1 cycle for rejected data accesses).
// Requesters hold req until their ack; MEM_ARB_RR_EN selects round-robin instead of data-port priority on collisions.
module mem_port_arbiter #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_rw,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic [31:0] dm_rdata,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        grant_dm_q;
    logic        if_ack_q, dm_ack_q, dm_err_q;
    logic [31:0] if_rdata_q, dm_rdata_q;
    logic        ram_enable_q, ram_rw_q;
    logic [31:0] ram_addr_q, ram_din_q;
    logic [1:0]  ram_size_q;
    logic        dm_bad;
    logic        pick_dm_d;

`ifdef MEM_ARB_RR_EN
    logic last_dm_q;
    assign pick_dm_d = dm_req && (!if_req || !last_dm_q);
`else
    assign pick_dm_d = dm_req;
`endif

    assign dm_bad = (dm_size == 2'b11)
                 || (dm_size == 2'b01 && dm_addr[0])
                 || (dm_size == 2'b10 && dm_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            grant_dm_q   <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            dm_err_q     <= 1'b0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= 32'd0;
            ram_din_q    <= 32'd0;
            ram_size_q   <= 2'b10;
`ifdef MEM_ARB_RR_EN
            last_dm_q    <= 1'b0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            dm_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_dm_d) begin
                        grant_dm_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_dm_q  <= 1'b1;
`endif
                        // Rejected accesses leave the RAM bus untouched and never strobe.
                        if (dm_bad) begin
                            state_q  <= DONE;
                            dm_ack_q <= 1'b1;
                            dm_err_q <= 1'b1;
                        end else begin
                            ram_addr_q <= dm_addr;
                            ram_size_q <= dm_size;
                            ram_rw_q   <= dm_rw;
                            ram_din_q  <= dm_wdata;
                            state_q    <= SETUP;
                        end
                    end else if (if_req) begin
                        grant_dm_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        last_dm_q  <= 1'b0;
`endif
                        ram_addr_q <= if_addr & 32'hFFFF_FFFC;
                        ram_size_q <= 2'b10;
                        ram_rw_q   <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    ram_enable_q <= 1'b1;
                    cnt_q        <= 4'd0;
                    state_q      <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        ram_enable_q <= 1'b0;
                        state_q      <= DONE;
                        // Read data is taken at the end of the strobe window so it is valid alongside ack.
                        if (grant_dm_q) begin
                            dm_ack_q <= 1'b1;
                            if (!ram_rw_q) dm_rdata_q <= ram_dout;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= ram_dout;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign dm_ack     = dm_ack_q;
    assign dm_err     = dm_err_q;
    assign dm_rdata   = dm_rdata_q;
    assign ram_enable = ram_enable_q;
    assign ram_rw     = ram_rw_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_size   = ram_size_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed little-endian RAM model, ACCESS_CYCLES=1 and =3 instances.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, if_ack, dm_req, dm_rw, dm_ack, dm_err, ram_enable, ram_rw;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, ram_addr, ram_din, ram_dout;
    logic [1:0]  dm_size, ram_size;

    mem_port_arbiter #(.ACCESS_CYCLES(1)) u_dut (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_size(ram_size), .ram_dout(ram_dout)
    );

    logic        r3_rst, r3_if_req, r3_if_ack, r3_dm_req, r3_dm_rw, r3_dm_ack, r3_dm_err, r3_en, r3_rw;
    logic [31:0] r3_if_addr, r3_if_rdata, r3_dm_addr, r3_dm_wdata, r3_dm_rdata, r3_addr, r3_din, r3_dout;
    logic [1:0]  r3_dm_size, r3_size;

    mem_port_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(r3_rst),
        .if_req(r3_if_req), .if_addr(r3_if_addr), .if_ack(r3_if_ack), .if_rdata(r3_if_rdata),
        .dm_req(r3_dm_req), .dm_rw(r3_dm_rw), .dm_size(r3_dm_size), .dm_addr(r3_dm_addr),
        .dm_wdata(r3_dm_wdata), .dm_ack(r3_dm_ack), .dm_err(r3_dm_err), .dm_rdata(r3_dm_rdata),
        .ram_enable(r3_en), .ram_rw(r3_rw), .ram_addr(r3_addr), .ram_din(r3_din),
        .ram_size(r3_size), .ram_dout(r3_dout)
    );

    assign r3_dout = r3_addr ^ 32'hA5A5_0000;

    // Little-endian byte RAM, asynchronous read, write on the clock edge while strobed.
    logic [7:0] mem [0:63];
    logic [5:0] ra;
    assign ra = ram_addr[5:0];

    always_comb begin
        case (ram_size)
            2'b00:   ram_dout = {24'h0, mem[ra]};
            2'b01:   ram_dout = {16'h0, mem[ra + 6'd1], mem[ra]};
            default: ram_dout = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (ram_enable && ram_rw) begin
            mem[ra] <= ram_din[7:0];
            if (ram_size != 2'b00) mem[ra + 6'd1] <= ram_din[15:8];
            if (ram_size == 2'b10) begin
                mem[ra + 6'd2] <= ram_din[23:16];
                mem[ra + 6'd3] <= ram_din[31:24];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          en_cycles;
    } vec_t;

    vec_t vecs [10];

    task automatic do_dm(input logic rw_v, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                         input bit drop, output int lat, output int en_cnt, output logic [1:0] sz_seen,
                         output logic [31:0] ad_seen, output logic err, output logic [31:0] rd,
                         output int other_acks);
        @(negedge clk);
        dm_req = 1'b1; dm_rw = rw_v; dm_size = sz; dm_addr = ad; dm_wdata = wd;
        lat = -1; en_cnt = 0; other_acks = 0; sz_seen = 2'bxx; ad_seen = 'x; err = 1'bx; rd = 'x;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            if (drop && c == 1) dm_req = 1'b0;
            if (ram_enable) begin en_cnt++; sz_seen = ram_size; ad_seen = ram_addr; end
            if (if_ack) other_acks++;
            if (dm_ack) begin lat = c; err = dm_err; rd = dm_rdata; dm_req = 1'b0; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en_cnt, other, grants, both, last_c;
        logic [1:0] sz_seen;
        logic [31:0] ad_seen, rd, keep;
        logic err;
        logic [3:0] order;
        int first_en;

        vecs[0] = '{1'b0, 2'b10, 32'd8,  32'h0,        1'b0, 32'h1B1A1918, 3, 1};
        vecs[1] = '{1'b1, 2'b00, 32'd0,  32'h000000B5, 1'b0, 32'h1B1A1918, 3, 1};
        vecs[2] = '{1'b1, 2'b01, 32'd2,  32'h0000FFD3, 1'b0, 32'h1B1A1918, 3, 1};
        vecs[3] = '{1'b0, 2'b10, 32'd0,  32'h0,        1'b0, 32'hFFD311B5, 3, 1};
        vecs[4] = '{1'b0, 2'b01, 32'd3,  32'h0,        1'b1, 32'hFFD311B5, 1, 0};
        vecs[5] = '{1'b1, 2'b10, 32'd6,  32'hDEADBEEF, 1'b1, 32'hFFD311B5, 1, 0};
        vecs[6] = '{1'b0, 2'b11, 32'd0,  32'h0,        1'b1, 32'hFFD311B5, 1, 0};
        vecs[7] = '{1'b0, 2'b00, 32'd9,  32'h0,        1'b0, 32'h00000019, 3, 1};
        vecs[8] = '{1'b0, 2'b01, 32'd10, 32'h0,        1'b0, 32'h00001B1A, 3, 1};
        vecs[9] = '{1'b0, 2'b10, 32'd4,  32'h0,        1'b0, 32'h17161514, 3, 1};

        rst = 1'b1; r3_rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_rw = 0; dm_size = 2'b10; dm_addr = 0; dm_wdata = 0;
        r3_if_req = 0; r3_if_addr = 0; r3_dm_req = 0; r3_dm_rw = 0; r3_dm_size = 2'b10;
        r3_dm_addr = 0; r3_dm_wdata = 0;
        repeat (3) @(negedge clk);

        check("rst_ctrl", {25'd0, ram_enable, ram_rw, if_ack, dm_ack, dm_err, ram_size}, 32'h2);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_din", ram_din, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst3_ctrl", {25'd0, r3_en, r3_rw, r3_if_ack, r3_dm_ack, r3_dm_err, r3_size}, 32'h2);
        rst = 1'b0; r3_rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            do_dm(vecs[v].rw, vecs[v].size, vecs[v].addr, vecs[v].wdata, 1'b0,
                  lat, en_cnt, sz_seen, ad_seen, err, rd, other);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].err});
            check($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
            check($sformatf("v%0d_en_cycles", v), 32'(en_cnt), 32'(vecs[v].en_cycles));
            check($sformatf("v%0d_if_acks", v), 32'(other), 32'd0);
            if (en_cnt > 0) begin
                check($sformatf("v%0d_ram_size", v), {30'd0, sz_seen}, {30'd0, vecs[v].size});
                check($sformatf("v%0d_ram_addr", v), ad_seen, vecs[v].addr);
            end
        end

        // Fetch from an unaligned address is forced to the containing word.
        keep = dm_rdata;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h9;
        lat = -1; en_cnt = 0; other = 0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            if (ram_enable) begin
                en_cnt++;
                check("if_ram_bus", {ram_addr[29:0], ram_rw, ram_size}, {30'd8, 1'b0, 2'b10});
            end
            if (dm_ack) other++;
            if (if_ack) begin lat = c; if_req = 1'b0; check("if_rdata", if_rdata, 32'h1B1A1918); end
        end
        check("if_latency", 32'(lat), 32'd3);
        check("if_en_cycles", 32'(en_cnt), 32'd1);
        check("if_dm_acks", 32'(other), 32'd0);
        check("if_dm_rdata_kept", dm_rdata, keep);

        // Both ports requesting continuously for four grants.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_rw = 1'b0; dm_size = 2'b10; dm_addr = 32'd8;
        grants = 0; both = 0; last_c = 0; order = 4'b0;
        for (int c = 1; c <= 60 && grants < 4; c++) begin
            @(negedge clk);
            if (if_ack && dm_ack) both++;
            if (if_ack || dm_ack) begin
                order[grants] = dm_ack;
                if (grants > 0) check($sformatf("grant%0d_gap", grants), 32'(c - last_c), 32'd4);
                last_c = c;
                grants++;
                if (grants == 4) begin if_req = 1'b0; dm_req = 1'b0; end
            end
        end
        check("prio_grants", 32'(grants), 32'd4);
        check("prio_both_acks", 32'(both), 32'd0);
`ifdef MEM_ARB_RR_EN
        check("rr_order", {28'd0, order}, 32'h5);
`else
        check("prio_order", {28'd0, order}, 32'hF);
`endif
        other = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_ack || dm_ack || ram_enable) other++;
        end
        check("prio_quiet_after", 32'(other), 32'd0);

        // A request withdrawn right after grant still completes.
        do_dm(1'b0, 2'b10, 32'd4, 32'h0, 1'b1, lat, en_cnt, sz_seen, ad_seen, err, rd, other);
        check("drop_latency", 32'(lat), 32'd3);
        check("drop_rdata", rd, 32'h17161514);

        // Reset in the first STROBE cycle of a 3-cycle access.
        @(negedge clk);
        r3_dm_req = 1'b1; r3_dm_addr = 32'h40;
        first_en = -1;
        for (int c = 1; c <= 10 && first_en < 0; c++) begin
            @(negedge clk);
            if (r3_en) first_en = c;
        end
        check("r3_first_strobe", 32'(first_en), 32'd2);
        r3_rst = 1'b1; r3_dm_req = 1'b0;
        @(negedge clk);
        check("r3_abort_ctrl", {25'd0, r3_en, r3_rw, r3_if_ack, r3_dm_ack, r3_dm_err, r3_size}, 32'h2);
        check("r3_abort_addr", r3_addr, 32'h0);
        check("r3_abort_rdata", r3_dm_rdata, 32'h0);
        r3_rst = 1'b0;
        other = 0;
        repeat (8) begin
            @(negedge clk);
            if (r3_dm_ack || r3_if_ack || r3_en) other++;
        end
        check("r3_no_ack_after_abort", 32'(other), 32'd0);

        r3_dm_req = 1'b1; r3_dm_addr = 32'h20;
        lat = -1; en_cnt = 0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            if (r3_en) en_cnt++;
            if (r3_dm_ack) begin
                lat = c; r3_dm_req = 1'b0;
                check("r3_rdata", r3_dm_rdata, 32'hA5A50020);
                check("r3_err", {31'd0, r3_dm_err}, 32'd0);
            end
        end
        check("r3_latency", 32'(lat), 32'd5);
        check("r3_en_cycles", 32'(en_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
